// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side responder for the data cache's 128-bit
// line interface. One outstanding line read or line write at a time. Each
// request is answered LATENCY+1 cycles after it first appears, with a
// one-cycle mem_ready pulse.
//
// Optional feature: define CACHE_MEM_STATS_EN to add the saturating
// rd_count / wr_count completion counters. When the macro is undefined the
// counters and their ports are absent and nothing else changes.
module cache_mem_responder #(
    parameter int LATENCY = 8,   // acceptance-to-ready cycles, 1..255
    parameter int ADDR_W  = 10   // line-index bits, depth 2^ADDR_W
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         mem_err
`ifdef CACHE_MEM_STATS_EN
    ,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
`endif
);

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);
    localparam int         DEPTH    = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [7:0]          cnt;
    logic                is_wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [127:0]        wdata_q;
    logic [127:0]        mem_array [DEPTH];

    // decoded per-cycle actions from the FSM
    logic                accept;
    logic                commit;
    logic                abort;
    logic                cnt_dec;
    logic                req_live;

    // Upper address bits alias onto the array; they are deliberately dropped.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[27:ADDR_W];

    // The request that keeps a BUSY transaction alive is the one we latched,
    // so a write that arrived together with a read is judged on mem_write.
    assign req_live = is_wr_q ? mem_write : mem_read;

    // State register
    always_ff @(posedge clk) begin
        if (proc_reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state and action decode
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        commit  = 1'b0;
        abort   = 1'b0;
        cnt_dec = 1'b0;
        case (state)
            IDLE: begin
                if (mem_write || mem_read) begin
                    state_n = BUSY;
                    accept  = 1'b1;
                end
            end
            BUSY: begin
                if (!req_live) begin
                    state_n = IDLE;
                    abort   = 1'b1;
                end else if (cnt == 8'd0) begin
                    state_n = READY;
                    commit  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            READY: begin
                // Inputs are ignored here; a follow-on request is sampled in IDLE.
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Request capture, latency countdown, registered response and error flag
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            cnt       <= 8'd0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            // Pulse is registered off the BUSY->READY decision, so it is high
            // exactly during the READY cycle.
            mem_ready <= commit;
            if (accept) begin
                is_wr_q <= mem_write;
                addr_q  <= mem_addr[ADDR_W-1:0];
                wdata_q <= mem_wdata;
                cnt     <= CNT_INIT;
                if (mem_write && mem_read)
                    mem_err <= 1'b1;
            end else if (cnt_dec) begin
                cnt <= cnt - 8'd1;
            end
            if (commit && !is_wr_q)
                mem_rdata <= mem_array[addr_q];
        end
    end

    // Line array: not reset; a write lands only on a completed transaction,
    // so aborted or reset-interrupted writes never touch stored data.
    always_ff @(posedge clk) begin
        if (!proc_reset && commit && is_wr_q)
            mem_array[addr_q] <= wdata_q;
    end

`ifdef CACHE_MEM_STATS_EN
    // Completion counters, saturating; aborts never reach commit
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (commit) begin
            if (is_wr_q) begin
                if (wr_count != 16'hFFFF)
                    wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF)
                    rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder (LATENCY=4, ADDR_W=10): a table of
// line transactions issued back to back, then hand sequences for abort,
// error flag and reset in the middle of a transaction.
module tb_cache_mem_responder;

    localparam int LAT = 4;
    localparam int AW  = 10;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         mem_err;
`ifdef CACHE_MEM_STATS_EN
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;
`endif

    cache_mem_responder #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_err    (mem_err)
`ifdef CACHE_MEM_STATS_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int exp_rd = 0;
    int exp_wr = 0;
    logic [127:0] last_rd = '0;

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp;
    } vec_t;

    vec_t vt[7];

    localparam logic [127:0] D0 = 128'h11111111_11111111_11111111_00000000;
    localparam logic [127:0] DB = 128'hDEADBEEF_0BADF00D_CAFEBABE_13131313;
    localparam logic [127:0] DA = 128'h33333333_AAAAAAAA_55555555_03030303;
    localparam logic [127:0] DC = 128'h0401C0DE_FEEDFACE_12345678_9ABCDEF0;
    localparam logic [127:0] DE = 128'hE7E7E7E7_00000007_77777777_E0E0E0E0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: hold request until mem_ready, check latency, data and
    // pulse width; the caller's next request starts in the following IDLE cycle.
    task automatic txn(input string name, input bit wr, input bit rd, input logic [27:0] a,
                       input logic [127:0] d, input logic [127:0] exp_rdata, output int rdy_cyc);
        int n;
        bit seen;
        mem_write = wr;
        mem_read  = rd;
        mem_addr  = a;
        mem_wdata = d;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            step();
            n++;
            // once accepted, the live bus must no longer matter
            if (n == 1) begin
                mem_addr  = ~a;
                mem_wdata = ~d;
            end
            if (mem_ready) seen = 1;
        end
        check({name, "_latency"}, 128'(n), 128'(LAT + 1));
        check({name, "_rdata"}, mem_rdata, exp_rdata);
        rdy_cyc = cyc;
        if (seen) begin
            if (wr) exp_wr++;
            else    exp_rd++;
        end
        mem_write = 0;
        mem_read  = 0;
        step();
        check({name, "_pulse_width"}, 128'(mem_ready), 128'(0));
    endtask

    // Watch for a forbidden mem_ready pulse over n cycles; one comparison.
    task automatic no_pulse(input string name, input int n);
        bit hit;
        hit = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (mem_ready) hit = 1;
        end
        check(name, 128'(hit), 128'(0));
    endtask

    // Request held through `busy` BUSY cycles, then dropped before completion.
    task automatic abort_req(input string name, input bit wr, input logic [27:0] a,
                             input logic [127:0] d, input int busy);
        mem_write = wr;
        mem_read  = !wr;
        mem_addr  = a;
        mem_wdata = d;
        repeat (1 + busy) step();
        mem_write = 0;
        mem_read  = 0;
        no_pulse({name, "_no_ready"}, LAT + 4);
        check({name, "_rdata_held"}, mem_rdata, last_rd);
    endtask

    initial begin
        int rdy, prev_rdy;
        vt[0] = '{1'b1, 28'h0000005, D0, '0};
        vt[1] = '{1'b1, 28'h0000013, DB, '0};
        vt[2] = '{1'b1, 28'h0000003, DA, '0};
        vt[3] = '{1'b0, 28'h0000013, '0, DB};
        vt[4] = '{1'b1, 28'h0000401, DC, '0};
        vt[5] = '{1'b0, 28'h0000001, '0, DC};
        vt[6] = '{1'b0, 28'h0000005, '0, D0};

        proc_reset = 1;
        mem_read   = 0;
        mem_write  = 0;
        mem_addr   = '0;
        mem_wdata  = '0;
        repeat (3) step();
        proc_reset = 0;
        check("reset_ready", 128'(mem_ready), 128'(0));
        check("reset_rdata", mem_rdata, '0);
        check("reset_err", 128'(mem_err), 128'(0));

        // Back-to-back table: write-backs followed directly by allocates.
        prev_rdy = 0;
        for (int i = 0; i < 7; i++) begin
            if (!vt[i].wr) last_rd = vt[i].exp;
            txn($sformatf("vec%0d", i), vt[i].wr, !vt[i].wr, vt[i].addr, vt[i].wdata, last_rd, rdy);
            if (i > 0)
                check($sformatf("vec%0d_spacing", i), 128'(rdy - prev_rdy), 128'(LAT + 2));
            prev_rdy = rdy;
        end
        check("no_err_yet", 128'(mem_err), 128'(0));

        // Aborted read and aborted write leave rdata and array untouched.
        abort_req("abort_rd", 1'b0, 28'h0000013, '0, 2);
        abort_req("abort_wr", 1'b1, 28'h0000005, ~D0, 2);
        last_rd = D0;
        txn("rd_after_abort", 1'b0, 1'b1, 28'h0000005, '0, last_rd, rdy);

        // Both requests in IDLE: handled as a write, error flag sticks.
        txn("both_req", 1'b1, 1'b1, 28'h0000007, DE, last_rd, rdy);
        check("err_set", 128'(mem_err), 128'(1));
        last_rd = DE;
        txn("rd_both", 1'b0, 1'b1, 28'h0000007, '0, last_rd, rdy);
        check("err_sticky", 128'(mem_err), 128'(1));

`ifdef CACHE_MEM_STATS_EN
        check("rd_count", 128'(rd_count), 128'(exp_rd));
        check("wr_count", 128'(wr_count), 128'(exp_wr));
`endif

        // Reset during BUSY: write discarded, outputs cleared, no pulse.
        mem_write = 1;
        mem_addr  = 28'h0000005;
        mem_wdata = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
        repeat (3) step();
        mem_write  = 0;
        proc_reset = 1;
        step();
        proc_reset = 0;
        exp_rd = 0;
        exp_wr = 0;
        check("midrst_ready", 128'(mem_ready), 128'(0));
        check("midrst_rdata", mem_rdata, '0);
        check("midrst_err", 128'(mem_err), 128'(0));
`ifdef CACHE_MEM_STATS_EN
        check("midrst_rd_count", 128'(rd_count), 128'(0));
        check("midrst_wr_count", 128'(wr_count), 128'(0));
`endif
        no_pulse("midrst_no_ready", LAT + 4);
        last_rd = D0;
        txn("rd_after_rst", 1'b0, 1'b1, 28'h0000005, '0, last_rd, rdy);
`ifdef CACHE_MEM_STATS_EN
        check("post_rd_count", 128'(rd_count), 128'(exp_rd));
        check("post_wr_count", 128'(wr_count), 128'(exp_wr));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
